uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the 8N1 UART link, the receiving end of the team's UART transmitter. It oversamples the asynchronous `rxd` line with a 16× baud tick, recovers start, 8 data bits (LSB first) and stop, and presents each byte on a parallel bus with a one-cycle strobe. It sits between the board pin and the byte consumer, and shares the baud-tick generator with the transmitter.

## Interface
- `OVERSAMPLE`, 16: `tick` pulses per bit period. Fixed at 16 for this revision.
- `DATA_BITS`, 8: data bits per frame.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tick`  in  1  one-`clk` pulse at 16× baud rate; never high on consecutive cycles.
- `rxd`  in  1  asynchronous serial input; idles high.
- `data_out`  out  8  last correctly received byte; holds until the next good frame.
- `rx_done`  out  1  one-cycle strobe: `data_out` valid with a new byte.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Input conditioning: `rxd` passes through a 2-flop synchronizer (`rxs`), plus one more flop (`rxs_d`) for edge detection. All three flops reset to 1.
- Counters:
  - `s_cnt`: 4-bit tick counter; increments only on `tick` cycles.
  - `b_cnt`: 3-bit bit counter.
  - `shreg`: 8-bit shift register; right-shift, new bit enters at bit 7.
- States (2-bit encoding): IDLE=00, START=01, DATA=10, STOP=11.
- IDLE:
  - On `rxs_d==1 && rxs==0` (falling edge), go to START and clear `s_cnt`.
  - A line held low never retriggers START; a new 1→0 edge is required.
- START:
  - On the tick where `s_cnt==7` (mid start bit), check `rxs`.
  - If `rxs==0`: clear `s_cnt` and `b_cnt`, go to DATA.
  - If `rxs==1`: glitch. Return to IDLE with no strobe.
- DATA:
  - On the tick where `s_cnt==15`, shift `rxs` into `shreg` and clear `s_cnt`.
  - If `b_cnt==7`, go to STOP; otherwise increment `b_cnt`.
- STOP:
  - On the tick where `s_cnt==15`, sample `rxs` and go to IDLE.
  - If `rxs==1`: load `data_out<=shreg` and pulse `rx_done`.
  - If `rxs==0`: pulse `frame_err`; `data_out` is unchanged.
- `tick` low: counters, `shreg` and state hold. The edge detector in IDLE runs every `clk`, independent of `tick`.
- Reset while low (any state): state=IDLE, `s_cnt`=0, `b_cnt`=0, `shreg`=0, `data_out`=0x00, `rx_done`=0, `frame_err`=0, `busy`=0. Any frame in progress is dropped silently.

## Timing
- Reset values are as listed above. The first start edge is recognized at least 3 `clk` cycles after `rst_n` rises, once the synchronizer has flushed.
- Pin-to-detect latency: 2 `clk` cycles (synchronizer) plus 1 cycle (edge flop).
- `busy` rises on the clk after edge detection. It falls on the clk after the stop sample, in the same cycle that `rx_done`/`frame_err` is high.
- Sampling points, counted in ticks after edge detection:
  - start check at tick 8;
  - data bit k sampled at tick 8+16(k+1), k=0..7;
  - stop sampled at tick 152.
- `rx_done` and `frame_err` are registered, exactly one `clk` wide, and mutually exclusive.
- Simultaneous events:
  - A falling edge in the same cycle as the STOP sample is ignored (state is not yet IDLE). The next frame needs a fresh edge.
  - Back-to-back frames with a stop bit exactly 16 ticks long are accepted, because the stop bit is sampled at its midpoint.
- Minimum reliable `clk`/`tick` ratio: 2.

## Test plan
- Single byte: `tick` every 4 clk, frame 0xA5 (16 ticks/bit) → `rx_done` pulses once for 1 cycle at stop sample; `data_out`=0xA5; `frame_err`=0; `busy` high ≈152 ticks.
- Back-to-back: 0x00, 0xFF, 0x3C with no idle gap → three `rx_done` pulses; `data_out` sequence 0x00, 0xFF, 0x3C.
- Start glitch: `rxd` low for 4 ticks, then high → returns to IDLE; no strobes; `data_out` unchanged; `busy` low within ~8 ticks.
- Framing error: 0x55 with stop bit driven 0, then line held low 40 ticks → one `frame_err` pulse; no `rx_done`; `data_out` keeps the prior value. No new frame starts until `rxd` goes high and then falls again.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0x81, release, then send 0x7E → no strobe for 0x81; `rx_done` with `data_out`=0x7E.
- Loopback: connect the UART transmitter's `txd` to `rxd` and send 256 bytes 0x00..0xFF → 256 `rx_done` pulses; each byte matches; zero `frame_err`.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled start/data/stop recovery with a
// one-cycle strobe per byte (rx_done) or per bad stop bit (frame_err).
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_t;

    state_t               state_q;
    logic                 rxs_meta_q;
    logic                 rxs_q;
    logic                 rxs_dly_q;
    logic [SW-1:0]        s_cnt_q;
    logic [BW-1:0]        b_cnt_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 rx_done_q;
    logic                 frame_err_q;
    logic                 busy_q;

    // Synchronizer plus edge-detect flop; reset high so no false start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxs_meta_q <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_dly_q  <= 1'b1;
        end else begin
            rxs_meta_q <= rxd;
            rxs_q      <= rxs_meta_q;
            rxs_dly_q  <= rxs_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_cnt_q     <= '0;
            b_cnt_q     <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Edge detector runs every clk; a held-low line never retriggers.
                    if (rxs_dly_q && !rxs_q) begin
                        state_q <= START;
                        s_cnt_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_cnt_q == S_MID) begin
                            if (!rxs_q) begin
                                s_cnt_q <= '0;
                                b_cnt_q <= '0;
                                state_q <= DATA;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_cnt_q == S_LAST) begin
                            shreg_q <= {rxs_q, shreg_q[DATA_BITS-1:1]};
                            s_cnt_q <= '0;
                            if (b_cnt_q == B_LAST) state_q <= STOP;
                            else                   b_cnt_q <= b_cnt_q + 1'b1;
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s_cnt_q == S_LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (rxs_q) begin
                                data_q    <= shreg_q;
                                rx_done_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural 8N1 line driver pushes the
// expected strobe per frame; a monitor pops and compares on every strobe.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick;
    logic       rxd = 1'b1;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tick_div = 4;
    int   ph = 0;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .rxd      (rxd),
        .data_out (data_out),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ph >= tick_div - 1) ph <= 0;
        else                    ph <= ph + 1;
    end
    assign tick = (ph == tick_div - 1);

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        rxd = b;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 16);
        drive_bit(stop_bit, 16);
    endtask

    task automatic push(input bit err, input logic [7:0] d);
        exp_t e;
        e.err  = err;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rx_done || frame_err) begin
            exp_t e;
            check("strobe_exclusive", {7'd0, rx_done & frame_err}, 8'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: rx_done=%b frame_err=%b data_out=%h",
                         rx_done, frame_err, data_out);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", {7'd0, frame_err}, {7'd0, e.err});
                check("data_out", data_out, e.data);
            end
        end
    end

    initial begin
        logic [7:0] b;
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_data_out", data_out, 8'h00);
        check("reset_rx_done", {7'd0, rx_done}, 8'd0);
        check("reset_frame_err", {7'd0, frame_err}, 8'd0);
        check("reset_busy", {7'd0, busy}, 8'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single byte, with busy probed mid-frame and after.
        push(1'b0, 8'hA5);
        drive_bit(1'b0, 4);
        check("busy_in_frame", {7'd0, busy}, 8'd1);
        wait_ticks(12);
        for (int i = 0; i < 8; i++) drive_bit(b_bit(8'hA5, i), 16);
        drive_bit(1'b1, 16);
        wait_ticks(8);
        check("busy_after_frame", {7'd0, busy}, 8'd0);

        // Back-to-back frames, no idle gap.
        push(1'b0, 8'h00); send_frame(8'h00, 1'b1);
        push(1'b0, 8'hFF); send_frame(8'hFF, 1'b1);
        push(1'b0, 8'h3C); send_frame(8'h3C, 1'b1);
        wait_ticks(8);

        // Start glitch: short low pulse is rejected silently.
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 10);
        check("glitch_busy", {7'd0, busy}, 8'd0);
        check("glitch_data_out", data_out, 8'h3C);

        // Framing error, then line held low must not retrigger.
        push(1'b1, 8'h3C);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(b_bit(8'h55, i), 16);
        drive_bit(1'b0, 40);
        check("held_low_busy", {7'd0, busy}, 8'd0);
        check("ferr_data_out", data_out, 8'h3C);
        drive_bit(1'b1, 16);

        // Reset in the middle of data bit 3 of 0x81.
        drive_bit(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(b_bit(8'h81, i), 16);
        drive_bit(b_bit(8'h81, 3), 8);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_busy", {7'd0, busy}, 8'd0);
        check("midreset_data_out", data_out, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        push(1'b0, 8'h7E); send_frame(8'h7E, 1'b1);
        wait_ticks(16);

        // Loopback-style stream at the minimum clk/tick ratio.
        tick_div = 2;
        wait_ticks(4);
        for (int i = 0; i < 64; i++) begin
            b = 8'(i * 4 + (i & 3));
            push(1'b0, b);
            send_frame(b, 1'b1);
        end
        wait_ticks(32);

        check("pending_expected", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic b_bit(input logic [7:0] v, input int i);
        return v[i];
    endfunction

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
